lot_counter: RTL and testbench
==============================

Name: lot_counter

Overview:
Parametrised parking-lot occupancy counter driven by a two-beam gate sensor pair. It synchronises the raw sensor inputs and decodes entry and exit direction with a sequence FSM. It keeps a saturating occupancy count and drives four active-low 7-segment HEX outputs. The HEX digits show the remaining spots in decimal, or "FULL" when the lot is full. It sits between the DE1 GPIO sensor pins and HEX3..HEX0 at top level.

Parameters:
CAPACITY, 25, number of spots; legal range 1..99.
SYNC_STAGES, 2, flops per sensor synchroniser; minimum 2.
(derived) CW = $clog2(CAPACITY+1), width of count.

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
sensor_a  in  1  outer beam, 1 = blocked, asynchronous to clk
sensor_b  in  1  inner beam, 1 = blocked, asynchronous to clk
count  out  CW  cars currently in lot
full  out  1  count == CAPACITY
empty  out  1  count == 0
enter  out  1  one-cycle pulse on completed entry
exit  out  1  one-cycle pulse on completed exit
err  out  1  sticky flag: entry at full or exit at empty
hx0..hx3  out  7 each  7-seg, active-low, bit6=g .. bit0=a; hx0 is rightmost

Behaviour:
- Reset (async assert, sync release): sync flops 0, FSM=IDLE, count=0, enter=exit=0, err=0. The display then shows CAPACITY.
- Synchroniser: sa_s/sb_s = sensor_a/b delayed SYNC_STAGES flops. The FSM sees only sa_s/sb_s, written ab below.
- FSM states: IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, WAIT.
  - IDLE: 10->IN1; 01->OUT1; 11->WAIT; 00 stay.
  - IN1: 11->IN2; 00->IDLE (abort, no count); 10 stay; 01->WAIT.
  - IN2: 01->IN3; 10->IN1 (backing out); 11 stay; 00->WAIT.
  - IN3: 00->IDLE with entry event; 11->IN2; 01 stay; 10->WAIT.
  - OUT1..OUT3: mirror of IN1..IN3 with a and b swapped. OUT3 with 00 -> IDLE plus exit event.
  - WAIT: stay until 00, then IDLE; never counts.
- Entry event, on that same clock edge:
  - count <= count+1 if count<CAPACITY.
  - Otherwise count holds and err <= 1.
  - enter <= 1 for exactly one cycle in either case.
- Exit event: symmetric. Decrement if count>0, else hold and set err. exit pulses one cycle.
- Latency: count, enter and exit update on edge SYNC_STAGES+1 after raw inputs settle to 00. With default parameters that is the 3rd rising edge.
- full and empty are combinational from count.
- err clears only on reset.
- Display: rem = CAPACITY - count, combinational from registered count, so it is glitch-free per cycle.
  - full=1: hx3..hx0 = F,U,L,L = 0001110, 1000001, 1000111, 1000111.
  - Otherwise: hx0 = ones digit of rem; hx1 = tens digit, blank (1111111) when rem<10; hx2 = hx3 = blank.
  - Digit codes 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Reset mid-sequence returns the FSM to IDLE and discards the partial sequence. A car still under a beam when reset releases is routed to WAIT or treated as a new sequence per the IDLE rules.
- Inputs held 11 indefinitely: the FSM stays in its current state and count is unchanged.

Test Plan:
(CAPACITY=12, SYNC_STAGES=2)
1. Assert reset for 2 cycles, then release -> count=0, empty=1, full=0, err=0; hx1=1111001 ("1"), hx0=0100100 ("2"), hx2=hx3=1111111.
2. Apply ab = 10,11,01,00, each held 4 cycles -> enter high exactly 1 cycle, 3 edges after 00; count=1; hx0=1111001, hx1=1111001 ("11"). Then apply 01,11,10,00 -> exit pulse; count=0.
3. Aborted entries: 10,00 and 10,11,10,00 -> no enter pulse; count stays 0. Illegal jump 00->11->00 -> FSM passes through WAIT; count unchanged.
4. Three entries from reset -> rem=9, hx1 blank, hx0=0010000. Continue to 12 entries -> full=1, hx3..hx0 = FULL codes. One more entry -> enter pulses, count stays 12, err=1 and stays 1.
5. From empty, one exit sequence -> exit pulses, count=0, err=1.
6. Assert reset async, mid-clock, while the FSM is in IN2 with count=5 -> count=0 and outputs reset immediately without waiting for an edge. Hold ab=11 after release -> WAIT, no count change.

Source files
------------

// File: rtl/lot_counter.sv
// Parking-lot occupancy counter: synchronises a two-beam gate sensor, decodes
// entry/exit direction, keeps a saturating count and drives four 7-seg digits.
module lot_counter #(
  parameter int CAPACITY    = 25,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sensor_a,
  input  logic          sensor_b,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          enter,
  output logic          exit,
  output logic          err,
  output logic [6:0]    hx0,
  output logic [6:0]    hx1,
  output logic [6:0]    hx2,
  output logic [6:0]    hx3
);

  localparam logic [CW-1:0] CAP_W = CW'(CAPACITY);
  localparam logic [6:0]    BLANK = 7'b1111111;

  typedef enum logic [2:0] {
    ST_IDLE, ST_IN1, ST_IN2, ST_IN3, ST_OUT1, ST_OUT2, ST_OUT3, ST_WAIT
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [1:0]             ab;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], sensor_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], sensor_b};
    end
  end

  assign ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  // Valid/ready does not apply here: enter/exit are single-cycle event strobes
  // registered on the same edge that commits the count change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      enter <= 1'b0;
      exit  <= 1'b0;
      err   <= 1'b0;
    end else begin
      enter <= 1'b0;
      exit  <= 1'b0;
      case (state)
        ST_IDLE:
          case (ab)
            2'b10:   state <= ST_IN1;
            2'b01:   state <= ST_OUT1;
            2'b11:   state <= ST_WAIT;
            default: state <= ST_IDLE;
          endcase
        ST_IN1:
          case (ab)
            2'b11:   state <= ST_IN2;
            2'b00:   state <= ST_IDLE;
            2'b10:   state <= ST_IN1;
            default: state <= ST_WAIT;
          endcase
        ST_IN2:
          case (ab)
            2'b01:   state <= ST_IN3;
            2'b10:   state <= ST_IN1;
            2'b11:   state <= ST_IN2;
            default: state <= ST_WAIT;
          endcase
        ST_IN3:
          case (ab)
            2'b00: begin
              state <= ST_IDLE;
              enter <= 1'b1;
              if (count < CAP_W) count <= count + CW'(1);
              else               err   <= 1'b1;
            end
            2'b11:   state <= ST_IN2;
            2'b01:   state <= ST_IN3;
            default: state <= ST_WAIT;
          endcase
        ST_OUT1:
          case (ab)
            2'b11:   state <= ST_OUT2;
            2'b00:   state <= ST_IDLE;
            2'b01:   state <= ST_OUT1;
            default: state <= ST_WAIT;
          endcase
        ST_OUT2:
          case (ab)
            2'b10:   state <= ST_OUT3;
            2'b01:   state <= ST_OUT1;
            2'b11:   state <= ST_OUT2;
            default: state <= ST_WAIT;
          endcase
        ST_OUT3:
          case (ab)
            2'b00: begin
              state <= ST_IDLE;
              exit  <= 1'b1;
              if (count != '0) count <= count - CW'(1);
              else             err   <= 1'b1;
            end
            2'b11:   state <= ST_OUT2;
            2'b10:   state <= ST_OUT3;
            default: state <= ST_WAIT;
          endcase
        ST_WAIT:
          if (ab == 2'b00) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign full  = (count == CAP_W);
  assign empty = (count == '0);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = BLANK;
    endcase
  endfunction

  logic [6:0] rem;
  logic [3:0] ones;
  logic [3:0] tens;

  // Remaining spots are derived from the registered count only, so the
  // display changes once per clock and never shows intermediate values.
  always_comb begin
    rem  = 7'(CAPACITY) - 7'(count);
    ones = 4'(rem % 7'd10);
    tens = 4'(rem / 7'd10);
    if (full) begin
      hx3 = 7'b0001110;
      hx2 = 7'b1000001;
      hx1 = 7'b1000111;
      hx0 = 7'b1000111;
    end else begin
      hx3 = BLANK;
      hx2 = BLANK;
      hx1 = (rem < 7'd10) ? BLANK : seg7(tens);
      hx0 = seg7(ones);
    end
  end

endmodule

// File: tb/tb_lot_counter.sv
// Bench for lot_counter: vector table, directed corner sequences and random
// gate traffic checked every cycle against a path-position reference model.
module tb_lot_counter;

  localparam int CAP = 12;
  localparam int SS  = 2;
  localparam int CW  = $clog2(CAP + 1);
  localparam logic [6:0] BLANK = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset;
  logic          sensor_a;
  logic          sensor_b;
  logic [CW-1:0] count;
  logic          full, empty, enter, exit, err;
  logic [6:0]    hx0, hx1, hx2, hx3;

  lot_counter #(.CAPACITY(CAP), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .count(count), .full(full), .empty(empty), .enter(enter), .exit(exit),
    .err(err), .hx0(hx0), .hx1(hx1), .hx2(hx2), .hx3(hx3)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
  localparam logic [27:0] FULL_DISP = {7'b0001110, 7'b1000001, 7'b1000111, 7'b1000111};

  // Reference model: a car is tracked by direction and position along its
  // beam path (entry path codes 00,10,11,01,00; exit path swaps a and b).
  logic [SS-1:0] m_sa, m_sb;
  int   m_dir;     // 0 none, 1 entering, -1 leaving, 2 waiting for clear
  int   m_pos;
  int   m_count;
  logic m_enter, m_exit, m_err;

  task automatic model_reset();
    m_sa = '0; m_sb = '0;
    m_dir = 0; m_pos = 0; m_count = 0;
    m_enter = 0; m_exit = 0; m_err = 0;
  endtask

  function automatic int path_pos(input int dir, input logic [1:0] code, input int pos);
    logic [1:0] first, third;
    first = (dir == 1) ? 2'b10 : 2'b01;
    third = (dir == 1) ? 2'b01 : 2'b10;
    if (code == first) return 1;
    if (code == 2'b11) return 2;
    if (code == third) return 3;
    if (pos == 1) return 0;
    if (pos == 3) return 4;
    return -9;
  endfunction

  task automatic model_step(input logic a, input logic b);
    logic [1:0] code;
    int tgt;
    code = {m_sa[SS-1], m_sb[SS-1]};
    m_enter = 0; m_exit = 0;
    if (m_dir == 2) begin
      if (code == 2'b00) m_dir = 0;
    end else if (m_dir == 0) begin
      if (code == 2'b10)      begin m_dir = 1;  m_pos = 1; end
      else if (code == 2'b01) begin m_dir = -1; m_pos = 1; end
      else if (code == 2'b11) m_dir = 2;
    end else begin
      tgt = path_pos(m_dir, code, m_pos);
      if (tgt - m_pos > 1 || m_pos - tgt > 1) m_dir = 2;
      else if (tgt == 0) m_dir = 0;
      else if (tgt == 4) begin
        if (m_dir == 1) begin
          m_enter = 1;
          if (m_count < CAP) m_count++; else m_err = 1;
        end else begin
          m_exit = 1;
          if (m_count > 0) m_count--; else m_err = 1;
        end
        m_dir = 0;
      end else m_pos = tgt;
    end
    m_sa = {m_sa[SS-2:0], a};
    m_sb = {m_sb[SS-2:0], b};
  endtask

  function automatic logic [27:0] exp_disp(input int c);
    int rem;
    logic [6:0] tens;
    if (c == CAP) return FULL_DISP;
    rem  = CAP - c;
    tens = (rem < 10) ? BLANK : seg_tab[rem / 10];
    return {BLANK, BLANK, tens, seg_tab[rem % 10]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("count", 32'(count), 32'(m_count));
    check("enter", 32'(enter), 32'(m_enter));
    check("exit",  32'(exit),  32'(m_exit));
    check("err",   32'(err),   32'(m_err));
    check("full",  32'(full),  32'(m_count == CAP));
    check("empty", 32'(empty), 32'(m_count == 0));
    check("disp",  32'({hx3, hx2, hx1, hx0}), 32'(exp_disp(m_count)));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_step(sensor_a, sensor_b);
    #1 compare_all();
  endtask

  task automatic drive(input logic [1:0] ab, input int n);
    sensor_a = ab[1];
    sensor_b = ab[0];
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic do_entry();
    drive(2'b10, 3); drive(2'b11, 3); drive(2'b01, 3); drive(2'b00, 4);
  endtask

  task automatic do_exit();
    drive(2'b01, 3); drive(2'b11, 3); drive(2'b10, 3); drive(2'b00, 4);
  endtask

  typedef struct {
    logic [1:0]    ab;
    int            hold;
    logic [CW-1:0] exp_count;
    logic          exp_err;
  } vec_t;

  vec_t vecs [16];

  initial begin
    vecs[0]  = '{2'b10, 4, 0, 0};
    vecs[1]  = '{2'b11, 4, 0, 0};
    vecs[2]  = '{2'b01, 4, 0, 0};
    vecs[3]  = '{2'b00, 4, 1, 0};
    vecs[4]  = '{2'b01, 4, 1, 0};
    vecs[5]  = '{2'b11, 4, 1, 0};
    vecs[6]  = '{2'b10, 4, 1, 0};
    vecs[7]  = '{2'b00, 4, 0, 0};
    vecs[8]  = '{2'b10, 4, 0, 0};
    vecs[9]  = '{2'b00, 4, 0, 0};
    vecs[10] = '{2'b10, 4, 0, 0};
    vecs[11] = '{2'b11, 4, 0, 0};
    vecs[12] = '{2'b10, 4, 0, 0};
    vecs[13] = '{2'b00, 4, 0, 0};
    vecs[14] = '{2'b11, 4, 0, 0};
    vecs[15] = '{2'b00, 4, 0, 0};

    reset = 1'b1; sensor_a = 1'b0; sensor_b = 1'b0;
    model_reset();

    // Reset state and initial display "12"
    do_reset();
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_hx1", 32'(hx1), 32'(7'b1111001));
    check("rst_hx0", 32'(hx0), 32'(7'b0100100));
    check("rst_hx32", 32'({hx3, hx2}), 32'({BLANK, BLANK}));

    // Entry, exit, aborted entries and illegal jump
    foreach (vecs[i]) begin
      drive(vecs[i].ab, vecs[i].hold);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      if (i == 3) check("vec3_hx", 32'({hx1, hx0}), 32'({7'b1111001, 7'b1111001}));
    end

    // Fill to capacity, then overflow
    do_reset();
    repeat (3) do_entry();
    check("rem9_hx1", 32'(hx1), 32'(BLANK));
    check("rem9_hx0", 32'(hx0), 32'(7'b0010000));
    repeat (9) do_entry();
    check("full_flag", 32'(full), 1);
    check("full_disp", 32'({hx3, hx2, hx1, hx0}), 32'(FULL_DISP));
    do_entry();
    check("ovf_count", 32'(count), 12);
    check("ovf_err", 32'(err), 1);
    do_exit();
    check("after_ovf_count", 32'(count), 11);
    check("err_sticky", 32'(err), 1);

    // Exit from empty
    do_reset();
    do_exit();
    check("unf_count", 32'(count), 0);
    check("unf_err", 32'(err), 1);

    // Async reset mid-clock while a car is mid-entry
    do_reset();
    repeat (5) do_entry();
    drive(2'b10, 4); drive(2'b11, 4);
    @(negedge clk);
    #3 reset = 1'b1;
    #1 model_reset();
    check("async_count", 32'(count), 0);
    check("async_err", 32'(err), 0);
    compare_all();
    repeat (2) tick();
    @(negedge clk) reset = 1'b0;
    drive(2'b11, 6);
    check("hold11_count", 32'(count), 0);
    drive(2'b00, 5);
    check("clear_count", 32'(count), 0);

    // Random traffic
    do_reset();
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          drive(2'b10, $urandom_range(1, 4)); drive(2'b11, $urandom_range(1, 4));
          drive(2'b01, $urandom_range(1, 4)); drive(2'b00, $urandom_range(1, 4));
        end
        1: begin
          drive(2'b01, $urandom_range(1, 4)); drive(2'b11, $urandom_range(1, 4));
          drive(2'b10, $urandom_range(1, 4)); drive(2'b00, $urandom_range(1, 4));
        end
        default: drive(2'($urandom_range(0, 3)), $urandom_range(1, 5));
      endcase
    end
    drive(2'b00, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
